// File: rtl/usb_in_ep_buffer.sv
// Single-packet IN endpoint buffer: the endpoint fills and commits one packet, and the
// protocol engine reads it out once per IN token until the host ACKs it.
module usb_in_ep_buffer #(
    parameter int unsigned MAX_PKT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_ep_req,
    output logic       in_ep_grant,
    output logic       in_ep_data_free,
    input  logic       in_ep_data_put,
    input  logic [7:0] in_ep_data,
    input  logic       in_ep_data_done,
    input  logic       in_ep_stall,
    output logic       in_ep_acked,
    output logic       tx_pkt_ready,
    output logic       tx_pkt_stall,
    input  logic       tx_pkt_start,
    output logic       tx_data_avail,
    input  logic       tx_data_get,
    output logic [7:0] tx_data,
    output logic       tx_data_pid,
    input  logic       tx_ack_recv
);

    localparam int unsigned IW = $clog2(MAX_PKT);
    localparam int unsigned CW = IW + 1;
    localparam logic [CW-1:0] MaxCnt = CW'(MAX_PKT);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StReady
    } state_t;

    state_t        state;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] pkt_len;
    logic [CW-1:0] rd_ptr;
    logic [7:0]    mem [MAX_PKT];
    logic          put_ok;

    assign in_ep_grant     = (state == StFill);
    assign in_ep_data_free = (state == StFill) && (wr_count < MaxCnt);
    assign tx_pkt_ready    = (state == StReady);
    assign tx_data_avail   = (state == StReady) && (rd_ptr < pkt_len);
    assign tx_data         = mem[rd_ptr[IW-1:0]];
    assign put_ok          = in_ep_data_put && in_ep_data_free;

    // Buffer RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (put_ok) begin
            mem[wr_count[IW-1:0]] <= in_ep_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            wr_count     <= '0;
            pkt_len      <= '0;
            rd_ptr       <= '0;
            tx_data_pid  <= 1'b0;
            in_ep_acked  <= 1'b0;
            tx_pkt_stall <= 1'b0;
        end else begin
            in_ep_acked  <= 1'b0;
            tx_pkt_stall <= in_ep_stall;
            unique case (state)
                StIdle: begin
                    if (in_ep_req) begin
                        state <= StFill;
                    end
                end
                StFill: begin
                    if (put_ok) begin
                        wr_count <= wr_count + 1'b1;
                    end
                    if (in_ep_data_done) begin
                        pkt_len <= wr_count + CW'(put_ok);
                        rd_ptr  <= '0;
                        state   <= StReady;
                    end
                end
                StReady: begin
                    // ACK wins over a same-cycle IN token, which wins over a get.
                    if (tx_ack_recv) begin
                        state       <= StIdle;
                        wr_count    <= '0;
                        pkt_len     <= '0;
                        rd_ptr      <= '0;
                        tx_data_pid <= ~tx_data_pid;
                        in_ep_acked <= 1'b1;
                    end else if (tx_pkt_start) begin
                        rd_ptr <= '0;
                    end else if (tx_data_get && tx_data_avail) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/usb_in_ep_buffer.md
USB_IN_EP_BUFFER -- requirements
Module: usb_in_ep_buffer

Interface
REQ-001 SHALL have parameter: MAX_PKT, 64, maximum IN packet payload in bytes (power of two, 8..512).
REQ-002 SHALL have ports as follows:
- clk  input  1  sole clock.
- reset  input  1  synchronous reset, active-high.
- in_ep_req  input  1  endpoint logic requests buffer ownership.
- in_ep_grant  output  1  ownership granted; puts accepted.
- in_ep_data_free  output  1  buffer has room for one more byte.
- in_ep_data_put  input  1  write strobe for in_ep_data.
- in_ep_data  input  8  payload byte.
- in_ep_data_done  input  1  commit current packet.
- in_ep_stall  input  1  endpoint requests STALL handshake.
- in_ep_acked  output  1  one-cycle pulse: host ACKed committed packet.
- tx_pkt_ready  output  1  committed packet waiting for host IN token.
- tx_pkt_stall  output  1  protocol engine must answer IN with STALL.
- tx_pkt_start  input  1  one-cycle pulse: IN token received; rewind readout.
- tx_data_avail  output  1  tx_data holds an unread payload byte.
- tx_data_get  input  1  consume tx_data.
- tx_data  output  8  payload byte at read pointer.
- tx_data_pid  output  1  data toggle: 0 = DATA0, 1 = DATA1.
- tx_ack_recv  input  1  one-cycle pulse: host ACK received for this endpoint.

Function
REQ-003 SHALL implement states IDLE (buffer empty, not granted), FILL (granted, writing) and READY (packet committed, awaiting ACK).
REQ-004 SHALL transition IDLE->FILL on the cycle after in_ep_req=1 is sampled; in_ep_grant=1 exactly while in FILL.
REQ-005 SHALL ignore in_ep_req in FILL and READY.
REQ-006 SHALL drive in_ep_data_free=1 iff state==FILL and wr_count<MAX_PKT.
REQ-007 SHALL, on in_ep_data_put=1 with in_ep_data_free=1, store in_ep_data at wr_count and increment wr_count by 1.
REQ-008 SHALL silently drop puts when in_ep_data_free=0: full, or not in FILL.
REQ-009 SHALL, on in_ep_data_done=1 in FILL, latch pkt_len=wr_count (including any put in the same cycle) and enter READY next cycle.
REQ-010 SHALL treat done with no puts as a valid zero-length packet (pkt_len=0).
REQ-011 SHALL size wr_count, rd_ptr and pkt_len as clog2(MAX_PKT)+1 bits, so a full MAX_PKT count is representable without wrap.
REQ-012 SHALL drive tx_pkt_ready=1 iff state==READY.
REQ-013 SHALL, on tx_pkt_start=1 in READY, set rd_ptr=0 on the next cycle; every IN token thereby retransmits from byte 0.
REQ-014 SHALL drive tx_data_avail=1 iff state==READY and rd_ptr<pkt_len; tx_data SHALL equal stored byte[rd_ptr] whenever tx_data_avail=1.
REQ-015 SHALL increment rd_ptr by 1 on tx_data_get=1 with tx_data_avail=1 and ignore tx_data_get otherwise.
REQ-016 SHALL give tx_pkt_start priority over a simultaneous tx_data_get.
REQ-017 SHALL, on tx_ack_recv=1 in READY: enter IDLE, clear wr_count, pkt_len and rd_ptr, invert tx_data_pid, and pulse in_ep_acked=1 for exactly one cycle on the next cycle.
REQ-018 SHALL ignore tx_ack_recv outside READY, with no toggle and no acked pulse.
REQ-019 SHALL leave state and pointers unchanged on the absence of ACK (NAK/timeout); the packet stays buffered for retry.
REQ-020 SHALL register tx_pkt_stall from in_ep_stall with 1-cycle latency, independent of state; stall SHALL NOT modify buffer contents or the toggle.
REQ-021 SHALL, on a simultaneous tx_ack_recv and tx_pkt_start in READY, perform the ACK behaviour only.

Reset
REQ-022 SHALL, while reset=1 at a clk edge: state=IDLE, wr_count=pkt_len=rd_ptr=0, tx_data_pid=0, in_ep_grant=0, in_ep_data_free=0, in_ep_acked=0, tx_pkt_ready=0, tx_pkt_stall=0, tx_data_avail=0.
REQ-023 SHALL discard any partially filled or committed packet on reset in any state; buffer RAM contents need not be cleared.
REQ-024 SHALL NOT emit an in_ep_acked pulse as a consequence of reset.

Verification
REQ-025 SHALL cover this scenario: req, then put 0x41, 0x42, 0x43, with done on the last put -> tx_pkt_ready=1; after tx_pkt_start, 3 gets read 0x41, 0x42, 0x43 with tx_data_pid=0; ACK -> in_ep_acked pulses once, pid=1, tx_pkt_ready=0.
REQ-026 SHALL cover this scenario: put MAX_PKT+2 bytes 0x00.. -> in_ep_data_free drops after byte MAX_PKT-1; extra bytes dropped; done -> exactly MAX_PKT bytes read back.
REQ-027 SHALL cover this scenario: commit 2 bytes, start, get 1 byte, start again with no ACK -> readout restarts at byte 0; both bytes read; pid unchanged.
REQ-028 SHALL cover this scenario: done with no puts -> tx_pkt_ready=1, tx_data_avail=0; ACK -> pid toggles.
REQ-029 SHALL cover this scenario: reset asserted in FILL after 5 puts -> all outputs at reset values next cycle; new req/put/done of 1 byte reads back only that byte with pid=0.
REQ-030 SHALL cover this scenario: in_ep_stall=1 in READY -> tx_pkt_stall=1 one cycle later; tx_ack_recv pulse outside READY -> no in_ep_acked and no toggle.
